// File: rtl/snake_dir_input_if.sv
// Button, step and direction signals of the player-1 direction register.
// master drives the buttons and step; slave is the direction register itself.
interface snake_dir_input_if;
  logic        up;
  logic        down;
  logic        left;
  logic        right;
  logic        step;
  logic [31:0] move1;
  logic        dir_changed;
  logic [3:0]  btn_state;
  logic        req_drop;

  modport master (
    output up, down, left, right, step,
    input  move1, dir_changed, btn_state, req_drop
  );

  modport slave (
    input  up, down, left, right, step,
    output move1, dir_changed, btn_state, req_drop
  );
endinterface

// File: rtl/snake_dir_input.sv
// Debounced, step-synchronised snake direction register with reversal rejection.
// Define SNAKE_DIR_QUEUE_EN to buffer up to two turns, each applied on a step.
module snake_dir_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input logic              clock,
  input logic              resetn,
  snake_dir_input_if.slave bus
);

  typedef enum logic [2:0] {
    DIR_UP    = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_LEFT  = 3'd4
  } dir_e;

  function automatic logic turn_ok(dir_e req, dir_e cur);
    logic opposite;
    opposite = (req == DIR_UP    && cur == DIR_DOWN)  ||
               (req == DIR_DOWN  && cur == DIR_UP)    ||
               (req == DIR_RIGHT && cur == DIR_LEFT)  ||
               (req == DIR_LEFT  && cur == DIR_RIGHT);
    return (req != cur) && !opposite;
  endfunction

  // Bit order {up,right,down,left} matches btn_state and the priority order.
  logic [3:0]       raw;
  logic [3:0]       sync1, sync2, stable, stable_d, press;
  logic [CNT_W-1:0] cnt [4];
  dir_e             req, move_q, move_d, step_dir_q;
  logic             req_vld, accept, upd, dir_changed_q;

  assign raw = {bus.up, bus.right, bus.down, bus.left};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stable <= '1;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press pulse is registered one cycle after stable falls.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stable_d <= '1;
      press    <= '0;
    end else begin
      stable_d <= stable;
      press    <= stable_d & ~stable;
    end
  end

  always_comb begin
    req_vld = 1'b1;
    req     = DIR_UP;
    if (press[3])      req = DIR_UP;
    else if (press[2]) req = DIR_RIGHT;
    else if (press[1]) req = DIR_DOWN;
    else if (press[0]) req = DIR_LEFT;
    else               req_vld = 1'b0;
  end

`ifdef SNAKE_DIR_QUEUE_EN
  dir_e       fifo_q [2];
  dir_e       fifo_d [2];
  dir_e       cur;
  logic [1:0] count_q, count_d;
  logic       pop, push_ok, drop_q;

  // Turns are validated against the newest queued turn, so a queued pair
  // can never combine into a reversal once applied.
  always_comb begin
    cur = step_dir_q;
    if (count_q == 2'd2)      cur = fifo_q[1];
    else if (count_q == 2'd1) cur = fifo_q[0];
    pop     = bus.step && (count_q != 2'd0);
    accept  = req_vld && turn_ok(req, cur);
    push_ok = accept && ((count_q != 2'd2) || pop);
    fifo_d  = fifo_q;
    count_d = count_q;
    move_d  = move_q;
    upd     = pop;
    if (pop) begin
      move_d    = fifo_q[0];
      fifo_d[0] = fifo_q[1];
      count_d   = count_q - 2'd1;
    end
    if (push_ok) begin
      if (count_d == 2'd0) fifo_d[0] = req;
      else                 fifo_d[1] = req;
      count_d = count_d + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fifo_q  <= '{DIR_RIGHT, DIR_RIGHT};
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      fifo_q  <= fifo_d;
      count_q <= count_d;
      drop_q  <= accept && !push_ok;
    end
  end

  assign bus.req_drop = drop_q;
`else
  always_comb begin
    accept = req_vld && turn_ok(req, step_dir_q);
    move_d = accept ? req : move_q;
    upd    = accept;
  end

  assign bus.req_drop = 1'b0;
`endif

  // step_dir follows move1 as updated in the same cycle as the step.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      move_q        <= DIR_RIGHT;
      step_dir_q    <= DIR_RIGHT;
      dir_changed_q <= 1'b0;
    end else begin
      move_q        <= move_d;
      dir_changed_q <= upd;
      if (bus.step) step_dir_q <= move_d;
    end
  end

  assign bus.move1       = {29'd0, move_q};
  assign bus.dir_changed = dir_changed_q;
  assign bus.btn_state   = stable;

endmodule

// File: tb/tb_snake_dir_input.sv
// Scoreboard bench for snake_dir_input: stimulus queues predicted pulses
// (value and cycle), an independent monitor pops them on each output pulse.
module tb_snake_dir_input;
  localparam int unsigned D = 4;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  snake_dir_input_if bus();

  snake_dir_input #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    bit drop;
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   last_move  = 2;
  int   m_move     = 2;
  int   m_sd       = 2;
`ifdef SNAKE_DIR_QUEUE_EN
  int   m_fifo[$];
`endif

  function automatic void check(string name, int got, int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  function automatic int opposite(int code);
    return ((code + 1) % 4) + 1;
  endfunction

  function automatic bit legal(int code, int cur);
    return code != 0 && code != cur && opposite(code) != cur;
  endfunction

  // mask is {up,right,down,left}; priority up > right > down > left.
  function automatic int winner(logic [3:0] mask);
    int order [4] = '{1, 2, 3, 4};
    for (int k = 0; k < 4; k++)
      if (mask[3-k]) return order[k];
    return 0;
  endfunction

  // Reference behaviour for one cycle carrying a request code (0 = none)
  // and/or a step pulse; t is the cycle in which outputs must pulse.
  function automatic void model(int code, bit stepping, int t);
`ifdef SNAKE_DIR_QUEUE_EN
    int cur;
    bit ok;
    cur = (m_fifo.size() > 0) ? m_fifo[$] : m_sd;
    ok  = legal(code, cur);
    if (stepping && m_fifo.size() > 0) begin
      m_move = m_fifo.pop_front();
      exp_q.push_back('{1'b0, m_move, t});
    end
    if (stepping) m_sd = m_move;
    if (ok) begin
      if (m_fifo.size() < 2) m_fifo.push_back(code);
      else exp_q.push_back('{1'b1, 0, t});
    end
`else
    if (legal(code, m_sd)) begin
      m_move = code;
      exp_q.push_back('{1'b0, code, t});
    end
    if (stepping) m_sd = m_move;
`endif
  endfunction

  function automatic void model_reset();
    m_move = 2;
    m_sd   = 2;
`ifdef SNAKE_DIR_QUEUE_EN
    m_fifo.delete();
`endif
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    exp_t e;
    int   got_val;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (!resetn) begin
        last_move = 2;
      end else begin
        if (bus.dir_changed || bus.req_drop) begin
          compared++;
          got_val = bus.dir_changed ? int'(bus.move1) : 0;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_pulse: dir_changed=%0b req_drop=%0b move1=%0d at cycle %0d, none expected",
                     bus.dir_changed, bus.req_drop, bus.move1, cyc);
          end else begin
            e = exp_q.pop_front();
            if ((bus.req_drop != e.drop) || (bus.dir_changed == e.drop) ||
                (got_val != e.val) || (cyc != e.cyc)) begin
              mismatched++;
              $display("FAIL pulse: got drop=%0b move1=%0d cycle=%0d, expected drop=%0b move1=%0d cycle=%0d",
                       bus.req_drop, got_val, cyc, e.drop, e.val, e.cyc);
            end
          end
        end
        if (bus.dir_changed) begin
          last_move = int'(bus.move1);
        end else begin
          compared++;
          if (int'(bus.move1) != last_move) begin
            mismatched++;
            $display("FAIL move1_hold: got %0d, expected %0d at cycle %0d", bus.move1, last_move, cyc);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic release_all();
    {bus.up, bus.right, bus.down, bus.left} = 4'hf;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    drain();
    @(negedge clock);
    resetn = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check("reset_move1", int'(bus.move1), 2);
    check("reset_dir_changed", int'(bus.dir_changed), 0);
    check("reset_req_drop", int'(bus.req_drop), 0);
    check("reset_btn_state", int'(bus.btn_state), 15);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic press(input logic [3:0] mask, input bit step_evt);
    int n;
    @(negedge clock);
    n = cyc;
    {bus.up, bus.right, bus.down, bus.left} = ~mask;
    repeat (D + 3) @(negedge clock);
    bus.step = step_evt;
    model(winner(mask), step_evt, n + int'(D) + 4);
    @(negedge clock);
    bus.step = 1'b0;
    repeat (4) @(negedge clock);
    release_all();
    repeat (D + 6) @(negedge clock);
  endtask

  task automatic do_step();
    int n;
    @(negedge clock);
    n = cyc;
    bus.step = 1'b1;
    model(0, 1'b1, n + 1);
    @(negedge clock);
    bus.step = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic glitch(input logic [3:0] mask, input int len);
    @(negedge clock);
    {bus.up, bus.right, bus.down, bus.left} = ~mask;
    repeat (len) @(negedge clock);
    release_all();
    repeat (D + 6) @(negedge clock);
    check("glitch_btn_state", int'(bus.btn_state), 15);
  endtask

  initial begin : stimulus
    logic [3:0] mask;
    int         r;
    release_all();
    bus.step = 1'b0;
    resetn   = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("por_move1", int'(bus.move1), 2);
    check("por_dir_changed", int'(bus.dir_changed), 0);
    check("por_btn_state", int'(bus.btn_state), 15);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Latency: up press shows up D+4 cycles after the raw edge.
    press(4'b1000, 1'b0);
    glitch(4'b0001, 3);

    // Reversal rejection against step_dir.
    do_reset();
    press(4'b0001, 1'b0);
    press(4'b1000, 1'b0);
    press(4'b0001, 1'b0);
    do_step();
    press(4'b0001, 1'b0);
    do_step();
    do_step();

    // Simultaneous up and down: up wins.
    do_reset();
    press(4'b1010, 1'b0);
    press(4'b0100, 1'b1);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) mask = 4'b0001 << $urandom_range(0, 3);
      else mask = 4'($urandom_range(1, 15));
      if (r <= 4)      press(mask, 1'b0);
      else if (r <= 6) press(mask, 1'b1);
      else if (r <= 8) do_step();
      else             glitch(mask, $urandom_range(1, D - 1));
    end

    // Reset during a right debounce: a full fresh debounce follows release.
    drain();
    @(negedge clock);
    bus.right = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check("midreset_move1", int'(bus.move1), 2);
    check("midreset_btn_state", int'(bus.btn_state), 15);
    resetn = 1'b1;
    repeat (D + 1) @(negedge clock);
    check("post_reset_not_yet", int'(bus.btn_state), 15);
    @(negedge clock);
    check("post_reset_debounced", int'(bus.btn_state), 11);
    model(2, 1'b0, cyc + 2);
    repeat (4) @(negedge clock);
    release_all();
    repeat (D + 6) @(negedge clock);
    press(4'b1000, 1'b0);

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
